// File: rtl/ct_iu_pipe1_preg_bcast_if.sv
// ---------------------------------------------------------------------------
// ct_iu_pipe1_preg_bcast_if
//
// Bundles the pipe1 destination-preg broadcaster's handshake and bus signals.
//
//   Issue side (IQ -> broadcaster):
//     rtu_yy_xx_flush       pipeline flush
//     rf_inst_vld           pipe1 instruction issued in RF
//     rf_dst_vld            issued instruction writes a GPR
//     rf_dst_preg[6:0]      destination preg
//     rf_type[1:0]          00 ALU, 01 MULT, 10 DIV, 11 reserved
//     div_done              divider result ready next cycle
//
//   Broadcast side (broadcaster -> issue-queue dependency entries):
//     ctrl_xx_rf_pipe1_preg_lch_vld / dp_xx_rf_pipe1_dst_preg   ALU early wakeup
//     iu_idu_ex2_pipe1_mult_inst_vld / iu_idu_ex2_pipe1_preg    MULT early wakeup
//     iu_idu_div_inst_vld / iu_idu_div_preg                     DIV early wakeup
//     iu_idu_ex2_pipe1_wb_preg_vld / iu_idu_ex2_pipe1_wb_preg   write-back
//     iu_idu_div_busy                                           divide outstanding
//     iu_idu_pipe1_issue_stall                                  block pipe1 issue
//
// The broadcaster connects through the master modport; the issue/IDU side
// (or a testbench standing in for it) uses the slave modport.
// ---------------------------------------------------------------------------
interface ct_iu_pipe1_preg_bcast_if;

    logic       rtu_yy_xx_flush;
    logic       rf_inst_vld;
    logic       rf_dst_vld;
    logic [6:0] rf_dst_preg;
    logic [1:0] rf_type;
    logic       div_done;

    logic       ctrl_xx_rf_pipe1_preg_lch_vld;
    logic [6:0] dp_xx_rf_pipe1_dst_preg;
    logic       iu_idu_ex2_pipe1_mult_inst_vld;
    logic [6:0] iu_idu_ex2_pipe1_preg;
    logic       iu_idu_div_inst_vld;
    logic [6:0] iu_idu_div_preg;
    logic       iu_idu_ex2_pipe1_wb_preg_vld;
    logic [6:0] iu_idu_ex2_pipe1_wb_preg;
    logic       iu_idu_div_busy;
    logic       iu_idu_pipe1_issue_stall;

    modport master (
        input  rtu_yy_xx_flush,
        input  rf_inst_vld,
        input  rf_dst_vld,
        input  rf_dst_preg,
        input  rf_type,
        input  div_done,
        output ctrl_xx_rf_pipe1_preg_lch_vld,
        output dp_xx_rf_pipe1_dst_preg,
        output iu_idu_ex2_pipe1_mult_inst_vld,
        output iu_idu_ex2_pipe1_preg,
        output iu_idu_div_inst_vld,
        output iu_idu_div_preg,
        output iu_idu_ex2_pipe1_wb_preg_vld,
        output iu_idu_ex2_pipe1_wb_preg,
        output iu_idu_div_busy,
        output iu_idu_pipe1_issue_stall
    );

    modport slave (
        output rtu_yy_xx_flush,
        output rf_inst_vld,
        output rf_dst_vld,
        output rf_dst_preg,
        output rf_type,
        output div_done,
        input  ctrl_xx_rf_pipe1_preg_lch_vld,
        input  dp_xx_rf_pipe1_dst_preg,
        input  iu_idu_ex2_pipe1_mult_inst_vld,
        input  iu_idu_ex2_pipe1_preg,
        input  iu_idu_div_inst_vld,
        input  iu_idu_div_preg,
        input  iu_idu_ex2_pipe1_wb_preg_vld,
        input  iu_idu_ex2_pipe1_wb_preg,
        input  iu_idu_div_busy,
        input  iu_idu_pipe1_issue_stall
    );

endinterface

// File: rtl/ct_iu_pipe1_preg_bcast.sv
// ---------------------------------------------------------------------------
// ct_iu_pipe1_preg_bcast
//
// Producer-side destination-preg broadcaster for integer pipe1
// (ALU / MULT / DIV). Follows each issued instruction's destination preg
// down the pipe, drives the early-wakeup and write-back broadcast buses,
// arbitrates the single pipe1 write-back slot and back-pressures issue.
//
// Ports:
//   forever_cpuclk  clock, rising edge
//   cpurst_b        asynchronous active-low reset
//   bus             ct_iu_pipe1_preg_bcast_if.master (issue inputs and
//                   broadcast outputs, see the interface file)
//
// Latencies from issue cycle n:
//   ALU   lch_vld in n, write-back in n+2
//   MULT  early wakeup in n+2, write-back in n+3
//   DIV   early wakeup in d+1, write-back >= d+2 (d = div_done cycle)
// ---------------------------------------------------------------------------
module ct_iu_pipe1_preg_bcast (
    input  logic                          forever_cpuclk,
    input  logic                          cpurst_b,
    ct_iu_pipe1_preg_bcast_if.master      bus
);

    localparam logic [1:0] TYPE_ALU  = 2'b00;
    localparam logic [1:0] TYPE_MULT = 2'b01;
    localparam logic [1:0] TYPE_DIV  = 2'b10;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_WB   = 2'b10
    } div_state_t;

    logic       flush;
    logic       iss;
    logic       iss_alu;
    logic       iss_mult;
    logic       iss_div;

    logic       ex1_vld;
    logic       ex1_mult;
    logic [6:0] ex1_preg;
    logic       ex2_vld;
    logic [6:0] ex2_preg;

    div_state_t div_state;
    logic [6:0] div_preg_q;
    logic       div_inst_vld_q;

    logic       wb_vld_q;
    logic [6:0] wb_preg_q;

    logic       mult_wb_req;
    logic       alu_wb_req;
    logic       div_wb_req;
    logic       div_grant;
    logic       wb_sel_vld;
    logic [6:0] wb_sel_preg;

    // Issue qualification; reserved type 11 falls through every decode.
    assign flush    = bus.rtu_yy_xx_flush;
    assign iss      = bus.rf_inst_vld && bus.rf_dst_vld && !flush;
    assign iss_alu  = iss && (bus.rf_type == TYPE_ALU);
    assign iss_mult = iss && (bus.rf_type == TYPE_MULT);
    assign iss_div  = iss && (bus.rf_type == TYPE_DIV);

    // RF -> EX1 -> EX2 tracking. EX1 holds ALU and MULT; only MULT moves on
    // to EX2. The write-back register below plays the role of EX3 for MULT.
    // preg fields are not reset-sensitive to flush, only valids are.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ex1_vld  <= 1'b0;
            ex1_mult <= 1'b0;
            ex1_preg <= 7'd0;
            ex2_vld  <= 1'b0;
            ex2_preg <= 7'd0;
        end else begin
            ex1_vld <= (iss_alu || iss_mult) && !flush;
            ex2_vld <= ex1_vld && ex1_mult && !flush;
            if (iss_alu || iss_mult) begin
                ex1_mult <= iss_mult;
                ex1_preg <= bus.rf_dst_preg;
            end
            if (ex1_vld && ex1_mult) begin
                ex2_preg <= ex1_preg;
            end
        end
    end

    // Write-back slot arbitration: MULT in EX2, then ALU in EX1, then the
    // divide waiting in WB. The issue stall guarantees MULT and ALU never
    // collide, so only the divide can ever be held off.
    always_comb begin
        mult_wb_req = ex2_vld;
        alu_wb_req  = ex1_vld && !ex1_mult;
        div_wb_req  = (div_state == DIV_WB);
        div_grant   = div_wb_req && !mult_wb_req && !alu_wb_req;
        wb_sel_vld  = 1'b0;
        wb_sel_preg = 7'd0;
        if (mult_wb_req) begin
            wb_sel_vld  = 1'b1;
            wb_sel_preg = ex2_preg;
        end else if (alu_wb_req) begin
            wb_sel_vld  = 1'b1;
            wb_sel_preg = ex1_preg;
        end else if (div_grant) begin
            wb_sel_vld  = 1'b1;
            wb_sel_preg = div_preg_q;
        end
    end

    // Registered write-back broadcast. The preg only updates on a grant so
    // the bus holds its last value while idle.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            wb_vld_q  <= 1'b0;
            wb_preg_q <= 7'd0;
        end else begin
            wb_vld_q <= wb_sel_vld && !flush;
            if (wb_sel_vld && !flush) begin
                wb_preg_q <= wb_sel_preg;
            end
        end
    end

    // Divide tracker. A second divide issued while one is outstanding is
    // ignored, and div_done outside BUSY is ignored. The early wakeup pulses
    // on the BUSY->WB transition, i.e. during the first WB cycle. Flush
    // beats everything, including a coincident div_done.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            div_state      <= DIV_IDLE;
            div_preg_q     <= 7'd0;
            div_inst_vld_q <= 1'b0;
        end else begin
            div_inst_vld_q <= 1'b0;
            if (flush) begin
                div_state <= DIV_IDLE;
            end else begin
                case (div_state)
                    DIV_IDLE: begin
                        if (iss_div) begin
                            div_state  <= DIV_BUSY;
                            div_preg_q <= bus.rf_dst_preg;
                        end
                    end
                    DIV_BUSY: begin
                        if (bus.div_done) begin
                            div_state      <= DIV_WB;
                            div_inst_vld_q <= 1'b1;
                        end
                    end
                    DIV_WB: begin
                        if (div_grant) begin
                            div_state <= DIV_IDLE;
                        end
                    end
                    default: begin
                        div_state <= DIV_IDLE;
                    end
                endcase
            end
        end
    end

    // The first stall term keeps an ALU from landing its n+2 write-back on
    // top of the MULT's n+3 one; the second lets the waiting divide win the
    // slot within two cycles.
    assign bus.iu_idu_pipe1_issue_stall       = (ex1_vld && ex1_mult) || (div_state == DIV_WB);

    assign bus.ctrl_xx_rf_pipe1_preg_lch_vld  = iss_alu;
    assign bus.dp_xx_rf_pipe1_dst_preg        = bus.rf_dst_preg;
    assign bus.iu_idu_ex2_pipe1_mult_inst_vld = ex2_vld;
    assign bus.iu_idu_ex2_pipe1_preg          = ex2_preg;
    assign bus.iu_idu_div_inst_vld            = div_inst_vld_q;
    assign bus.iu_idu_div_preg                = div_preg_q;
    assign bus.iu_idu_ex2_pipe1_wb_preg_vld   = wb_vld_q;
    assign bus.iu_idu_ex2_pipe1_wb_preg       = wb_preg_q;
    assign bus.iu_idu_div_busy                = (div_state != DIV_IDLE);

endmodule
